lsu_pipe: RTL and testbench
===========================

// Module: lsu_pipe
// PURPOSE
//  Pipelined load/store unit for the EX->MEM->WB path. Accepts one memory op per cycle (valid/ready),
//  computes address and byte strobes, drives an SRAM-like bus (req/addr_ok, data_ok) with up to
//  MAX_OUTSTANDING in-flight accesses, and returns in-order results with load alignment and extension.
// PARAMETERS
//  MAX_OUTSTANDING  2   accesses accepted by the bus (addr_ok seen) but not yet completed (data_ok); 1..4
//  RESP_DEPTH       2   response FIFO entries toward WB; RESP_DEPTH >= MAX_OUTSTANDING
// PORTS
//  clk                input   1   clock, rising edge
//  reset              input   1   asynchronous, active-high reset
//  in_valid           input   1   EX presents an op
//  in_ready           output  1   op accepted when in_valid & in_ready
//  load_op            input   6   one-hot {ld_b, ld_h, ld_w, ld_bu, ld_hu, ll_w}
//  store_op           input   3   one-hot {st_b, st_h, st_w}; load_op and store_op never both non-zero
//  rj_value           input   32  base register
//  rkd_value          input   32  store data
//  imm                input   32  sign-extended offset
//  flush              input   1   pipeline flush (exception/branch)
//  data_sram_req      output  1   bus request
//  data_sram_wr       output  1   1 = store
//  data_sram_size     output  2   0 byte, 1 half, 2 word
//  data_sram_wstrb    output  4   byte write strobes
//  data_sram_addr     output  32  byte address
//  data_sram_wdata    output  32  replicated store data
//  data_sram_addr_ok  input   1   request accepted this cycle
//  data_sram_data_ok  input   1   oldest outstanding access completes; rdata valid
//  data_sram_rdata    input   32  read data
//  out_valid          output  1   result available
//  out_ready          input   1   WB consumes result
//  out_is_load        output  1   result belongs to a load
//  out_rdata          output  32  aligned, extended load data (0 for stores)
//  out_ale            output  1   address-misalign exception
//  out_badv           output  32  faulting address (valid with out_ale)
// BEHAVIOUR
//  - Reset: in_ready=0, data_sram_req=0, out_valid=0, out_ale=0, all data outputs 0, counters/FIFOs empty.
//  - addr = rj_value + imm (mod 2^32). wstrb: st_b -> 1<<addr[1:0]; st_h -> 4'b0011<<addr[1:0]; st_w -> 4'hF.
//    wdata: st_b {4{rkd[7:0]}}, st_h {2{rkd[15:0]}}, st_w rkd. ll_w behaves as ld_w.
//  - Request register: accepted op held with req=1 and all bus fields stable until addr_ok; req drops
//    the cycle after addr_ok unless a new op was accepted in the same cycle (back-to-back allowed).
//  - in_ready = !(req & !addr_ok) & (inflight + resp_count + req_pending < RESP_DEPTH) & inflight < MAX_OUTSTANDING.
//    data_ok is never stalled: a response slot is reserved at acceptance.
//  - data_ok pops oldest inflight tag {op, addr[1:0], cancel}; result pushed to response FIFO same edge.
//    Load extract: byte = rdata >> 8*addr[1:0], half = rdata >> 16*addr[1]; ld_b/ld_h sign-extend,
//    ld_bu/ld_hu zero-extend. Latency accept->out_valid: 1 + bus latency (min 2 cycles with addr_ok and
//    data_ok each one cycle after).
//  - Simultaneous addr_ok and data_ok: push and pop in same cycle, inflight count unchanged.
//  - flush: clears response FIFO, drops an un-accepted request (req=0 next cycle), marks all inflight
//    tags cancel; cancelled data_ok is consumed without pushing. in_ready held 0 until inflight == 0.
//  - Results leave strictly in program order; out_* fields stable while out_valid & !out_ready.
//  - reset mid-transaction: all state cleared immediately; the bus is reset together with this block.
// CONFIGURATION
//  LSU_ALIGN_CHECK_EN defined: ld_h/ld_hu/st_h with addr[0]!=0, or word ops with addr[1:0]!=0, issue
//   no bus request; a response with out_ale=1, out_badv=addr, out_rdata=0 is pushed in order
//   (after all older inflight results).
//  Not defined: no check; addr[1:0] forced to 0 for words and addr[0] to 0 for halves on the bus;
//   out_ale tied 0, out_badv tied 0.
// STRUCTURE
//  Shared package lsu_pkg: one-hot index localparams for load_op/store_op, SIZE_B/H/W encodings,
//  tag struct width {op 4, off 2, cancel 1}.
//  Sub-module lsu_resp_fifo (parametrised depth, in-order, push/pop same cycle, sync clear on flush);
//  instanced for the inflight tag queue and the response queue.
// TESTING
//  1 st_b rj=0x1000 imm=3 rkd=0xA5 -> addr 0x1003, wstrb 4'b1000, wdata 0xA5A5A5A5, out_is_load=0.
//  2 ld_b addr 0x2001, rdata 0x0000_80FF -> out_rdata 0xFFFF_FF80; ld_hu addr 0x2002 rdata 0xBEEF_0000 -> 0x0000_BEEF.
//  3 three ld_w back-to-back, addr_ok immediate, data_ok 3 cycles late, MAX_OUTSTANDING=2 -> third
//    stalled (in_ready=0) until first data_ok; results in order.
//  4 out_ready=0 for 10 cycles with RESP_DEPTH=2 -> exactly 2 ops accepted, no data_ok lost.
//  5 flush with 2 inflight loads -> no out_valid from them; in_ready returns after second data_ok.
//  6 LSU_ALIGN_CHECK_EN: ld_w addr 0x3002 -> no req, out_ale=1, out_badv=0x3002; without macro -> bus addr 0x3000.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared op indices, size codes, inflight tag layout and load extraction
package lsu_pkg;

    localparam int LD_B  = 5;
    localparam int LD_H  = 4;
    localparam int LD_W  = 3;
    localparam int LD_BU = 2;
    localparam int LD_HU = 1;
    localparam int LL_W  = 0;

    localparam int ST_B = 2;
    localparam int ST_H = 1;
    localparam int ST_W = 0;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    localparam logic [3:0] OP_ST  = 4'd0;
    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LW  = 4'd3;
    localparam logic [3:0] OP_LBU = 4'd4;
    localparam logic [3:0] OP_LHU = 4'd5;

    typedef struct packed {
        logic [3:0] op;
        logic [1:0] off;
        logic       cancel;
    } tag_t;

    localparam int TAG_W = $bits(tag_t);

    function automatic logic [31:0] load_extract(input logic [3:0] op, input logic [1:0] off,
                                                 input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(rdata >> {off, 3'b000});
        h = off[1] ? rdata[31:16] : rdata[15:0];
        return op == OP_LB  ? {{24{b[7]}}, b} :
               op == OP_LBU ? {24'd0, b} :
               op == OP_LH  ? {{16{h[15]}}, h} :
               op == OP_LHU ? {16'd0, h} :
               op == OP_LW  ? rdata : 32'd0;
    endfunction

endpackage

// File: rtl/lsu_resp_fifo.sv
// lsu_resp_fifo: in-order FIFO with same-cycle push/pop and synchronous clear
module lsu_resp_fifo #(
    parameter int W = 8,
    parameter int D = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               dout,
    output logic [$clog2(D+1)-1:0]     count
);
    localparam int AW = D > 1 ? $clog2(D) : 1;
    localparam int CW = $clog2(D + 1);

    logic [W-1:0]  mem [D];
    logic [AW-1:0] wp, rp;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(D - 1)) ? '0 : p + AW'(1);
    endfunction

    // pointers and occupancy; clear empties the queue without touching storage
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
        end else if (clear) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
        end else begin
            if (push) wp <= nxt(wp);
            if (pop) rp <= nxt(rp);
            count <= count + CW'(push) - CW'(pop);
        end

    // storage write
    always_ff @(posedge clk)
        if (push & !clear) mem[wp] <= din;

    assign dout = mem[rp];

endmodule

// File: rtl/lsu_pipe.sv
// lsu_pipe: pipelined load/store unit; LSU_ALIGN_CHECK_EN enables misalignment exceptions
module lsu_pipe
    import lsu_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int RESP_DEPTH      = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  load_op,
    input  logic [2:0]  store_op,
    input  logic [31:0] rj_value,
    input  logic [31:0] rkd_value,
    input  logic [31:0] imm,
    input  logic        flush,
    output logic        data_sram_req,
    output logic        data_sram_wr,
    output logic [1:0]  data_sram_size,
    output logic [3:0]  data_sram_wstrb,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    input  logic        data_sram_addr_ok,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_is_load,
    output logic [31:0] out_rdata,
    output logic        out_ale,
    output logic [31:0] out_badv
);
    localparam int TCW = $clog2(MAX_OUTSTANDING + 1);
    localparam int RCW = $clog2(RESP_DEPTH + 1);
    localparam int RW  = 34;

    logic [31:0]    addr_raw, addr_bus, ale_addr, wdata_n;
    logic [3:0]     op, req_op, wstrb_n;
    logic [1:0]     size;
    logic           is_st, mis, fire, pending, leave, ale_pend, ale_push, draining, cancel;
    logic           resp_push, resp_pop;
    logic [TCW-1:0] inflight;
    logic [RCW-1:0] resp_cnt;
    logic [RW-1:0]  resp_din, resp_dout;
    tag_t           tag_in, tag_out;
    int             inflight_nxt;

    assign addr_raw = rj_value + imm;
    assign is_st    = |store_op;
    assign op = is_st ? OP_ST : load_op[LD_B] ? OP_LB : load_op[LD_H] ? OP_LH :
                load_op[LD_BU] ? OP_LBU : load_op[LD_HU] ? OP_LHU :
                (load_op[LD_W] | load_op[LL_W]) ? OP_LW : OP_ST;
    assign size = (store_op[ST_B] | load_op[LD_B] | load_op[LD_BU]) ? SIZE_B :
                  (store_op[ST_H] | load_op[LD_H] | load_op[LD_HU]) ? SIZE_H : SIZE_W;

`ifdef LSU_ALIGN_CHECK_EN
    assign mis      = (size == SIZE_H & addr_raw[0]) | (size == SIZE_W & |addr_raw[1:0]);
    assign addr_bus = addr_raw;
`else
    assign mis      = 1'b0;
    assign addr_bus = size == SIZE_W ? {addr_raw[31:2], 2'b00} :
                      size == SIZE_H ? {addr_raw[31:1], 1'b0} : addr_raw;
`endif

    assign wstrb_n = store_op[ST_W] ? 4'hF :
                     store_op[ST_H] ? 4'b0011 << addr_bus[1:0] :
                     store_op[ST_B] ? 4'b0001 << addr_bus[1:0] : 4'h0;
    assign wdata_n = store_op[ST_B] ? {4{rkd_value[7:0]}} :
                     store_op[ST_H] ? {2{rkd_value[15:0]}} : rkd_value;

    // a misaligned op waits in the request slot until every older access has drained
    assign ale_push = ale_pend & (inflight == '0) & !flush;
    assign pending  = data_sram_req | ale_pend;
    assign leave    = data_sram_req ? data_sram_addr_ok : ale_push;
    // a response slot is reserved at acceptance so data_ok never needs to stall
    assign in_ready = !reset & !flush & !draining & !(pending & !leave) &
                      (int'(inflight) + int'(resp_cnt) + int'(pending) < RESP_DEPTH) &
                      (int'(inflight) < MAX_OUTSTANDING);
    assign fire = in_valid & in_ready;

    assign inflight_nxt = int'(inflight) + int'(data_sram_req & data_sram_addr_ok)
                          - int'(data_sram_data_ok);

    // request register: fields held stable until addr_ok, reloaded back-to-back on accept
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            data_sram_req   <= 1'b0;
            data_sram_wr    <= 1'b0;
            data_sram_size  <= 2'd0;
            data_sram_wstrb <= 4'd0;
            data_sram_addr  <= 32'd0;
            data_sram_wdata <= 32'd0;
            req_op          <= OP_ST;
            ale_pend        <= 1'b0;
            ale_addr        <= 32'd0;
        end else if (fire) begin
            data_sram_req   <= !mis;
            data_sram_wr    <= is_st;
            data_sram_size  <= size;
            data_sram_wstrb <= wstrb_n;
            data_sram_addr  <= addr_bus;
            data_sram_wdata <= wdata_n;
            req_op          <= op;
            ale_pend        <= mis;
            ale_addr        <= addr_raw;
        end else if (flush) begin
            data_sram_req <= 1'b0;
            ale_pend      <= 1'b0;
        end else begin
            if (data_sram_addr_ok) data_sram_req <= 1'b0;
            if (ale_push) ale_pend <= 1'b0;
        end

    // after a flush, every access still on the bus is discarded until the bus is empty
    always_ff @(posedge clk or posedge reset)
        if (reset) draining <= 1'b0;
        else draining <= (flush | draining) & (inflight_nxt != 0);

    assign tag_in = '{op: req_op, off: data_sram_addr[1:0], cancel: flush | draining};

    lsu_resp_fifo #(.W(TAG_W), .D(MAX_OUTSTANDING)) u_tag_q (
        .clk   (clk),
        .reset (reset),
        .clear (1'b0),
        .push  (data_sram_req & data_sram_addr_ok),
        .din   (tag_in),
        .pop   (data_sram_data_ok),
        .dout  (tag_out),
        .count (inflight)
    );

    assign cancel    = tag_out.cancel | draining | flush;
    assign resp_push = (data_sram_data_ok & !cancel) | ale_push;
    assign resp_din  = ale_push ? {req_op != OP_ST, 1'b1, ale_addr} :
                       {tag_out.op != OP_ST, 1'b0, load_extract(tag_out.op, tag_out.off, data_sram_rdata)};

    lsu_resp_fifo #(.W(RW), .D(RESP_DEPTH)) u_resp_q (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .push  (resp_push),
        .din   (resp_din),
        .pop   (resp_pop),
        .dout  (resp_dout),
        .count (resp_cnt)
    );

    assign out_valid   = resp_cnt != '0;
    assign resp_pop    = out_valid & out_ready;
    assign out_is_load = out_valid & resp_dout[33];
    assign out_rdata   = (out_valid & !resp_dout[32]) ? resp_dout[31:0] : 32'd0;

`ifdef LSU_ALIGN_CHECK_EN
    assign out_ale  = out_valid & resp_dout[32];
    assign out_badv = out_ale ? resp_dout[31:0] : 32'd0;
`else
    assign out_ale  = 1'b0;
    assign out_badv = 32'd0;
`endif

endmodule

// File: tb/tb_lsu_pipe.sv
// tb_lsu_pipe: directed self-checking bench for lsu_pipe with a latency-programmable bus model
module tb_lsu_pipe;

    logic        clk = 1'b0, reset = 1'b1, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b1, aok = 1'b1;
    logic [5:0]  load_op = '0;
    logic [2:0]  store_op = '0;
    logic [31:0] rj_value = '0, rkd_value = '0, imm = '0;
    logic        in_ready, data_sram_req, data_sram_wr, out_valid, out_is_load, out_ale;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr, data_sram_wdata, out_rdata, out_badv;
    logic        data_ok = 1'b0;
    logic [31:0] rdata = '0;

    int cyc = 0, dlat = 1, req_cnt = 0, dok_cnt = 0, acc_cnt = 0, n_chk = 0, n_err = 0;
    int          due_q[$];
    logic [31:0] rd_q[$];
    logic [31:0] cap_addr = '0, cap_wdata = '0;
    logic [3:0]  cap_wstrb = '0;
    logic        cap_wr = 1'b0;
    logic [1:0]  cap_size = '0;
    bit          g_ld[$], g_ale[$];
    logic [31:0] g_rd[$], g_badv[$];

    localparam logic [5:0] LDB = 6'b100000, LDH = 6'b010000, LDW = 6'b001000;
    localparam logic [5:0] LDBU = 6'b000100, LDHU = 6'b000010, LLW = 6'b000001;
    localparam logic [2:0] STB = 3'b100, STH = 3'b010, STW = 3'b001;

    always #5 clk = ~clk;

    lsu_pipe dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .load_op(load_op), .store_op(store_op), .rj_value(rj_value), .rkd_value(rkd_value),
        .imm(imm), .flush(flush),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
        .data_sram_wstrb(data_sram_wstrb), .data_sram_addr(data_sram_addr),
        .data_sram_wdata(data_sram_wdata), .data_sram_addr_ok(aok),
        .data_sram_data_ok(data_ok), .data_sram_rdata(rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_is_load(out_is_load),
        .out_rdata(out_rdata), .out_ale(out_ale), .out_badv(out_badv)
    );

    // bus model: accept on addr_ok, complete in order dlat cycles later
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (data_ok) begin
            dok_cnt <= dok_cnt + 1;
            if (due_q.size() > 0) void'(due_q.pop_front());
            if (rd_q.size() > 0) void'(rd_q.pop_front());
        end
        if (data_sram_req && aok) begin
            due_q.push_back(cyc + dlat);
            req_cnt   <= req_cnt + 1;
            cap_addr  <= data_sram_addr;
            cap_wdata <= data_sram_wdata;
            cap_wstrb <= data_sram_wstrb;
            cap_wr    <= data_sram_wr;
            cap_size  <= data_sram_size;
        end
    end

    // bus response drive and output monitor, away from the active edge
    always @(negedge clk) begin
        data_ok <= due_q.size() > 0 && cyc >= due_q[0];
        rdata   <= rd_q.size() > 0 ? rd_q[0] : 32'd0;
        if (in_valid && in_ready) acc_cnt <= acc_cnt + 1;
        if (out_valid && out_ready) begin
            g_ld.push_back(out_is_load);
            g_ale.push_back(out_ale);
            g_rd.push_back(out_rdata);
            g_badv.push_back(out_badv);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [5:0] ld, input logic [2:0] st, input logic [31:0] rj,
                         input logic [31:0] im, input logic [31:0] rk);
        load_op = ld; store_op = st; rj_value = rj; imm = im; rkd_value = rk; in_valid = 1'b1;
        for (int i = 0; i < 60 && !in_ready; i++) tick();
        if (!in_ready) chk("issue_timeout", 32'(in_ready), 32'd1);
        else tick();
        in_valid = 1'b0; load_op = '0; store_op = '0;
    endtask

    task automatic wait_res(input int n);
        for (int i = 0; i < 100 && g_rd.size() < n; i++) tick();
        chk("res_count", g_rd.size(), n);
    endtask

    task automatic exp_res(input string t, input bit ld, input logic [31:0] rd);
        if (g_rd.size() == 0) chk({t, "_missing"}, 32'd0, 32'd1);
        else begin
            chk({t, "_is_load"}, 32'(g_ld.pop_front()), 32'(ld));
            chk({t, "_ale"}, 32'(g_ale.pop_front()), 32'd0);
            chk({t, "_rdata"}, g_rd.pop_front(), rd);
            void'(g_badv.pop_front());
        end
    endtask

    initial begin
        int b0, b1, nres;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_req", 32'(data_sram_req), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_rdata", out_rdata, 32'd0);
        chk("rst_addr", data_sram_addr, 32'd0);
        reset = 1'b0;
        tick();
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        // stores: strobes, replication, address
        issue(6'd0, STB, 32'h1000, 32'd3, 32'hA5);
        wait_res(1);
        chk("stb_addr", cap_addr, 32'h1003);
        chk("stb_wstrb", 32'(cap_wstrb), 32'h8);
        chk("stb_wdata", cap_wdata, 32'hA5A5A5A5);
        chk("stb_wr", 32'(cap_wr), 32'd1);
        chk("stb_size", 32'(cap_size), 32'd0);
        exp_res("stb", 1'b0, 32'd0);
        issue(6'd0, STH, 32'h3000, 32'd2, 32'h12345678);
        wait_res(1);
        chk("sth_wstrb", 32'(cap_wstrb), 32'hC);
        chk("sth_wdata", cap_wdata, 32'h56785678);
        exp_res("sth", 1'b0, 32'd0);
        issue(6'd0, STW, 32'h3000, 32'd4, 32'hDEADBEEF);
        wait_res(1);
        chk("stw_wstrb", 32'(cap_wstrb), 32'hF);
        chk("stw_wdata", cap_wdata, 32'hDEADBEEF);
        exp_res("stw", 1'b0, 32'd0);

        // loads: extraction and extension
        rd_q.push_back(32'h000080FF);
        rd_q.push_back(32'hBEEF0000);
        rd_q.push_back(32'h12348001);
        rd_q.push_back(32'hC3000000);
        rd_q.push_back(32'hCAFEF00D);
        issue(LDB, 3'd0, 32'h2000, 32'd1, 32'd0);
        issue(LDHU, 3'd0, 32'h2000, 32'd2, 32'd0);
        issue(LDH, 3'd0, 32'h2000, 32'd0, 32'd0);
        issue(LDBU, 3'd0, 32'h2000, 32'd3, 32'd0);
        issue(LLW, 3'd0, 32'h2000, 32'd4, 32'd0);
        wait_res(5);
        exp_res("ldb", 1'b1, 32'hFFFFFF80);
        exp_res("ldhu", 1'b1, 32'h0000BEEF);
        exp_res("ldh", 1'b1, 32'hFFFF8001);
        exp_res("ldbu", 1'b1, 32'h000000C3);
        exp_res("llw", 1'b1, 32'hCAFEF00D);

        // three back-to-back words with slow data_ok: third must stall
        dlat = 3;
        rd_q.push_back(32'd1);
        rd_q.push_back(32'd2);
        rd_q.push_back(32'd3);
        b0 = dok_cnt;
        issue(LDW, 3'd0, 32'h4000, 32'd0, 32'd0);
        issue(LDW, 3'd0, 32'h4004, 32'd0, 32'd0);
        chk("b2b_stall", 32'(in_ready), 32'd0);
        issue(LDW, 3'd0, 32'h4008, 32'd0, 32'd0);
        chk("b2b_third_after_dok", 32'(dok_cnt - b0 >= 1), 32'd1);
        wait_res(3);
        exp_res("b2b_1", 1'b1, 32'd1);
        exp_res("b2b_2", 1'b1, 32'd2);
        exp_res("b2b_3", 1'b1, 32'd3);

        // WB stalled: only RESP_DEPTH ops accepted, no completion lost
        dlat = 1;
        out_ready = 1'b0;
        rd_q.push_back(32'h11);
        rd_q.push_back(32'h22);
        b0 = acc_cnt;
        b1 = dok_cnt;
        load_op = LDW; rj_value = 32'h5000; imm = 32'd0; in_valid = 1'b1;
        repeat (10) tick();
        in_valid = 1'b0; load_op = '0;
        chk("stall_accepted", acc_cnt - b0, 32'd2);
        chk("stall_data_ok", dok_cnt - b1, 32'd2);
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        chk("stall_out_rdata_hold", out_rdata, 32'h11);
        out_ready = 1'b1;
        wait_res(2);
        exp_res("stall_1", 1'b1, 32'h11);
        exp_res("stall_2", 1'b1, 32'h22);

        // flush with two loads inflight
        dlat = 3;
        rd_q.push_back(32'hAA);
        rd_q.push_back(32'hBB);
        b0 = dok_cnt;
        nres = g_rd.size();
        issue(LDW, 3'd0, 32'h6000, 32'd0, 32'd0);
        issue(LDW, 3'd0, 32'h6004, 32'd0, 32'd0);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_in_ready_low", 32'(in_ready), 32'd0);
        for (int i = 0; i < 40 && !in_ready; i++) tick();
        chk("flush_ready_back", 32'(in_ready), 32'd1);
        chk("flush_dok_before_ready", dok_cnt - b0, 32'd2);
        repeat (3) tick();
        chk("flush_no_results", g_rd.size(), nres);
        chk("flush_rd_consumed", rd_q.size(), 32'd0);

        // flush drops a request the bus has not accepted
        dlat = 1;
        aok = 1'b0;
        b0 = req_cnt;
        issue(LDW, 3'd0, 32'h7000, 32'd0, 32'd0);
        tick();
        chk("hold_req", 32'(data_sram_req), 32'd1);
        chk("hold_addr", data_sram_addr, 32'h7000);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("drop_req", 32'(data_sram_req), 32'd0);
        aok = 1'b1;
        repeat (3) tick();
        chk("drop_no_bus", req_cnt - b0, 32'd0);
        chk("drop_in_ready", 32'(in_ready), 32'd1);
        chk("drop_no_result", 32'(out_valid), 32'd0);

        // misaligned word
`ifdef LSU_ALIGN_CHECK_EN
        b0 = req_cnt;
        issue(LDW, 3'd0, 32'h3000, 32'd2, 32'd0);
        wait_res(1);
        chk("ale_no_req", req_cnt - b0, 32'd0);
        if (g_rd.size() > 0) begin
            chk("ale_is_load", 32'(g_ld.pop_front()), 32'd1);
            chk("ale_flag", 32'(g_ale.pop_front()), 32'd1);
            chk("ale_badv", g_badv.pop_front(), 32'h3002);
            chk("ale_rdata", g_rd.pop_front(), 32'd0);
        end
`else
        rd_q.push_back(32'h12345678);
        issue(LDW, 3'd0, 32'h3000, 32'd2, 32'd0);
        wait_res(1);
        chk("unal_bus_addr", cap_addr, 32'h3000);
        exp_res("unal", 1'b1, 32'h12345678);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
